// File: rtl/num_pkg.sv
// Shared types for the numeric word path: the int/shortreal word union,
// the frame assembler states and the IEEE-754 single field positions.
package num_pkg;

  typedef union packed {
    logic [31:0] raw;
    int          i;
  } num_word_t;

  typedef enum logic [2:0] {
    TAG  = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    B3   = 3'd4,
    HOLD = 3'd5
  } asm_state_e;

  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_MSB = 22;
  localparam int MAN_LSB = 0;

  // Field masks let classifiers test the fields without slicing off the sign bit.
  localparam logic [31:0] EXP_MASK = ((32'd1 << (EXP_MSB - EXP_LSB + 1)) - 32'd1) << EXP_LSB;
  localparam logic [31:0] MAN_MASK = ((32'd1 << (MAN_MSB - MAN_LSB + 1)) - 32'd1) << MAN_LSB;

endpackage

// File: rtl/num_classify.sv
// Combinational shortreal classifier: flags NaN and +/-infinity encodings.
module num_classify
  import num_pkg::*;
(
  input  logic [31:0] word_i,
  output logic        nan_o,
  output logic        inf_o
);

  logic expAllOnes;
  logic manZero;

  assign expAllOnes = (word_i & EXP_MASK) == EXP_MASK;
  assign manZero    = (word_i & MAN_MASK) == 32'd0;
  assign nan_o      = expAllOnes && !manZero;
  assign inf_o      = expAllOnes && manZero;

endmodule

// File: rtl/num_word_assembler.sv
// Assembles tagged 5-byte frames into 32-bit numeric words with a valid/ready
// hand-off; frames with unknown tags are consumed, dropped and counted.
module num_word_assembler
  import num_pkg::*;
#(
  parameter logic [7:0] TAG_INT  = 8'h00,
  parameter logic [7:0] TAG_REAL = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_is_real,
  output logic        out_nan,
  output logic        out_inf,
  output logic        err_pulse,
  output logic [7:0]  err_cnt
);

  asm_state_e state_q, state_d;
  logic        bad_q, bad_d;
  logic        real_q, real_d;
  logic [23:0] payload_q, payload_d;
  num_word_t   word_q, word_d;
  logic        outValid_q, outValid_d;
  logic        isReal_q, isReal_d;
  logic        nan_q, nan_d;
  logic        inf_q, inf_d;
  logic        errPulse_q, errPulse_d;
  logic [7:0]  errCnt_q, errCnt_d;

  logic        inAccept;
  logic [31:0] assembled;
  logic        clsNan, clsInf;

  // Payload bytes shift in from the top so b0 ends up in the low byte.
  assign assembled = {in_data, payload_q};
  assign inAccept  = in_valid && (state_q != HOLD);

  num_classify u_classify (
    .word_i (assembled),
    .nan_o  (clsNan),
    .inf_o  (clsInf)
  );

  always_comb begin
    state_d    = state_q;
    bad_d      = bad_q;
    real_d     = real_q;
    payload_d  = payload_q;
    word_d     = word_q;
    outValid_d = outValid_q;
    isReal_d   = isReal_q;
    nan_d      = nan_q;
    inf_d      = inf_q;
    errPulse_d = 1'b0;
    errCnt_d   = errCnt_q;

    case (state_q)
      TAG: begin
        if (inAccept) begin
          real_d  = (in_data == TAG_REAL);
          bad_d   = !((in_data == TAG_INT) || (in_data == TAG_REAL));
          state_d = B0;
        end
      end
      B0, B1, B2: begin
        if (inAccept) begin
          payload_d = {in_data, payload_q[23:8]};
          state_d   = asm_state_e'(state_q + 3'd1);
        end
      end
      B3: begin
        if (inAccept) begin
          // A bad frame is only judged here so its payload bytes are still swallowed.
          if (bad_q) begin
            errPulse_d = 1'b1;
            if (errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
            state_d = TAG;
          end else begin
            word_d.raw = assembled;
            isReal_d   = real_q;
            nan_d      = real_q && clsNan;
            inf_d      = real_q && clsInf;
            outValid_d = 1'b1;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          state_d    = TAG;
        end
      end
      default: state_d = TAG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TAG;
      bad_q      <= 1'b0;
      real_q     <= 1'b0;
      payload_q  <= '0;
      word_q     <= '0;
      outValid_q <= 1'b0;
      isReal_q   <= 1'b0;
      nan_q      <= 1'b0;
      inf_q      <= 1'b0;
      errPulse_q <= 1'b0;
      errCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      bad_q      <= bad_d;
      real_q     <= real_d;
      payload_q  <= payload_d;
      word_q     <= word_d;
      outValid_q <= outValid_d;
      isReal_q   <= isReal_d;
      nan_q      <= nan_d;
      inf_q      <= inf_d;
      errPulse_q <= errPulse_d;
      errCnt_q   <= errCnt_d;
    end
  end

  assign in_ready    = (state_q != HOLD);
  assign out_valid   = outValid_q;
  assign out_word    = word_q.raw;
  assign out_is_real = isReal_q;
  assign out_nan     = nan_q;
  assign out_inf     = inf_q;
  assign err_pulse   = errPulse_q;
  assign err_cnt     = errCnt_q;

endmodule

// File: tb/tb_num_word_assembler.sv
// Randomized self-checking bench for num_word_assembler against a frame-level model.
module tb_num_word_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic        out_is_real;
  logic        out_nan;
  logic        out_inf;
  logic        err_pulse;
  logic [7:0]  err_cnt;

  int checks = 0;
  int passes = 0;
  int errs   = 0;

  num_word_assembler dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_is_real (out_is_real),
    .out_nan     (out_nan),
    .out_inf     (out_inf),
    .err_pulse   (err_pulse),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Expected {out_valid, out_word, out_is_real, out_nan, out_inf} for a good frame.
  function automatic logic [35:0] model_out(input logic [7:0] tag, input logic [7:0] b0,
                                            input logic [7:0] b1, input logic [7:0] b2,
                                            input logic [7:0] b3);
    longint w, e, m;
    logic [31:0] wl;
    logic isReal, nan, inf;
    w = longint'(b0) + 256 * longint'(b1) + 65536 * longint'(b2) + 16777216 * longint'(b3);
    e = (w / 8388608) % 256;
    m = w % 8388608;
    wl = w[31:0];
    isReal = (tag == 8'h01);
    nan = isReal && (e == 255) && (m != 0);
    inf = isReal && (e == 255) && (m == 0);
    return {1'b1, wl, isReal, nan, inf};
  endfunction

  function automatic int sat_inc(input int n);
    return (n < 255) ? n + 1 : 255;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({in_ready, out_valid, out_word, out_is_real, out_nan, out_inf, err_pulse, err_cnt} !== {1'b1, 1'b0, 32'h0, 3'b000, 1'b0, 8'h00})
      $display("[TB] FAIL reset_state got=%h exp=%h",
               {in_ready, out_valid, out_word, out_is_real, out_nan, out_inf, err_pulse, err_cnt},
               {1'b1, 1'b0, 32'h0, 3'b000, 1'b0, 8'h00});
    else passes++;
    rst = 1'b0;
    errs = 0;
  endtask

  task automatic test_int_frame();
    logic [35:0] exp;
    out_ready = 1'b1;
    exp = model_out(8'h00, 8'h78, 8'h56, 8'h34, 8'h12);
    send_byte(8'h00); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL int_early_valid got=%b exp=0", out_valid); else passes++;
    send_byte(8'h12);
    checks++;
    if ({out_valid, out_word, out_is_real, out_nan, out_inf} !== exp)
      $display("[TB] FAIL int_word got=%h exp=%h", {out_valid, out_word, out_is_real, out_nan, out_inf}, exp);
    else passes++;
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL int_handoff got=%b exp=01", {out_valid, in_ready}); else passes++;
  endtask

  task automatic test_real_frames();
    logic [7:0] f [3][5];
    logic [35:0] exp;
    f[0] = '{8'h01, 8'h00, 8'h00, 8'h80, 8'h3F};
    f[1] = '{8'h01, 8'h01, 8'h00, 8'hC0, 8'h7F};
    f[2] = '{8'h01, 8'h00, 8'h00, 8'h80, 8'hFF};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp = model_out(f[k][0], f[k][1], f[k][2], f[k][3], f[k][4]);
      for (int j = 0; j < 5; j++) send_byte(f[k][j]);
      checks++;
      if ({out_valid, out_word, out_is_real, out_nan, out_inf} !== exp)
        $display("[TB] FAIL real_frame%0d got=%h exp=%h", k, {out_valid, out_word, out_is_real, out_nan, out_inf}, exp);
      else passes++;
      tick();
    end
  endtask

  task automatic test_bad_tag();
    logic [35:0] exp;
    out_ready = 1'b1;
    send_byte(8'h07); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    errs = sat_inc(errs);
    checks++;
    if ({out_valid, err_pulse, err_cnt} !== {1'b0, 1'b1, 8'(errs)})
      $display("[TB] FAIL bad_tag_err got=%h exp=%h", {out_valid, err_pulse, err_cnt}, {1'b0, 1'b1, 8'(errs)});
    else passes++;
    tick();
    checks++;
    if ({out_valid, err_pulse, in_ready} !== 3'b001)
      $display("[TB] FAIL bad_tag_pulse_end got=%b exp=001", {out_valid, err_pulse, in_ready});
    else passes++;
    exp = model_out(8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    send_byte(8'h00); send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    checks++;
    if ({out_valid, out_word, out_is_real, out_nan, out_inf} !== exp)
      $display("[TB] FAIL after_bad_word got=%h exp=%h", {out_valid, out_word, out_is_real, out_nan, out_inf}, exp);
    else passes++;
    tick();
  endtask

  task automatic test_backpressure();
    logic [35:0] exp;
    out_ready = 1'b0;
    exp = model_out(8'h01, 8'h11, 8'h22, 8'h33, 8'h44);
    send_byte(8'h01); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({in_ready, out_valid, out_word, out_is_real, out_nan, out_inf} !== {1'b0, exp})
        $display("[TB] FAIL backpressure_hold%0d got=%h exp=%h", c,
                 {in_ready, out_valid, out_word, out_is_real, out_nan, out_inf}, {1'b0, exp});
      else passes++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL backpressure_release got=%b exp=01", {out_valid, in_ready}); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    logic [35:0] exp;
    out_ready = 1'b1;
    send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    errs = 0;
    checks++;
    if ({in_ready, out_valid, out_word, out_is_real, out_nan, out_inf, err_pulse, err_cnt} !== {1'b1, 1'b0, 32'h0, 3'b000, 1'b0, 8'h00})
      $display("[TB] FAIL mid_reset_state got=%h exp=%h",
               {in_ready, out_valid, out_word, out_is_real, out_nan, out_inf, err_pulse, err_cnt},
               {1'b1, 1'b0, 32'h0, 3'b000, 1'b0, 8'h00});
    else passes++;
    rst = 1'b0;
    exp = model_out(8'h00, 8'h01, 8'h02, 8'h03, 8'h04);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    checks++;
    if ({out_valid, out_word, out_is_real, out_nan, out_inf} !== exp)
      $display("[TB] FAIL mid_reset_word got=%h exp=%h", {out_valid, out_word, out_is_real, out_nan, out_inf}, exp);
    else passes++;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] fr [5];
    logic [35:0] exp;
    int kind;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      fr[0] = (kind == 0) ? 8'($urandom_range(2, 255)) : (kind < 3 ? 8'h00 : 8'h01);
      for (int j = 1; j < 5; j++) fr[j] = 8'($urandom);
      if (kind >= 3 && $urandom_range(0, 1) == 1) begin
        fr[4] = {fr[4][7], 7'h7F};
        fr[3] = {1'b1, fr[3][6:0]};
        if ($urandom_range(0, 1) == 1) begin
          fr[1] = 8'h00; fr[2] = 8'h00; fr[3] = 8'h80;
        end
      end
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_byte(fr[j]);
      end
      if (kind == 0) begin
        errs = sat_inc(errs);
        checks++;
        if ({out_valid, err_pulse, err_cnt} !== {1'b0, 1'b1, 8'(errs)})
          $display("[TB] FAIL rand%0d_bad got=%h exp=%h", n, {out_valid, err_pulse, err_cnt}, {1'b0, 1'b1, 8'(errs)});
        else passes++;
      end else begin
        exp = model_out(fr[0], fr[1], fr[2], fr[3], fr[4]);
        checks++;
        if ({out_valid, out_word, out_is_real, out_nan, out_inf, err_pulse} !== {exp, 1'b0})
          $display("[TB] FAIL rand%0d_word got=%h exp=%h", n,
                   {out_valid, out_word, out_is_real, out_nan, out_inf, err_pulse}, {exp, 1'b0});
        else passes++;
        repeat ($urandom_range(0, 3)) tick();
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL rand%0d_handoff got=%b exp=01", n, {out_valid, in_ready}); else passes++;
      end
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    errs = 0;
    for (int n = 0; n < 260; n++) begin
      send_byte(8'hF0); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      errs = sat_inc(errs);
      if (n == 254 || n == 259) begin
        checks++;
        if ({err_pulse, err_cnt} !== {1'b1, 8'(errs)})
          $display("[TB] FAIL saturation_%0d got=%h exp=%h", n + 1, {err_pulse, err_cnt}, {1'b1, 8'(errs)});
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_int_frame();
    test_real_frames();
    test_bad_tag();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
